chunked_addsub: RTL and testbench

//  Parametrised multi-cycle adder/subtractor. Adds or subtracts two WIDTH-bit operands

---
 rtl/chunked_addsub.sv | 91 +++++++++
 tb/tb_chunked_addsub.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice per clock with a registered carry.
// Results are held from the done pulse until the next accepted start.
module chunked_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             ci,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {StIdle, StRun} stateT;

    stateT            state;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             carry;
    logic [IdxW-1:0]  idx;

    logic [CHUNK-1:0] sliceA;
    logic [CHUNK-1:0] sliceB;
    logic [CHUNK:0]   sliceSum;
    logic             carryIntoMsb;
    logic             lastChunk;

    always_comb begin
        sliceA       = opA[idx*CHUNK +: CHUNK];
        sliceB       = opB[idx*CHUNK +: CHUNK];
        sliceSum     = {1'b0, sliceA} + {1'b0, sliceB} + {{CHUNK{1'b0}}, carry};
        // Only meaningful on the last chunk, where bit CHUNK-1 is bit WIDTH-1 of the result.
        carryIntoMsb = sliceA[CHUNK-1] ^ sliceB[CHUNK-1] ^ sliceSum[CHUNK-1];
        lastChunk    = (idx == IdxW'(N - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= StIdle;
            ready <= 1'b1;
            done  <= 1'b0;
            sum   <= '0;
            co    <= 1'b0;
            ovf   <= 1'b0;
            opA   <= '0;
            opB   <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        // Subtraction is a + ~b + ~borrow.
                        opA   <= a;
                        opB   <= sub ? ~b : b;
                        carry <= sub ? ~ci : ci;
                        idx   <= '0;
                        ready <= 1'b0;
                        state <= StRun;
                    end
                end
                StRun: begin
                    sum[idx*CHUNK +: CHUNK] <= sliceSum[CHUNK-1:0];
                    carry                   <= sliceSum[CHUNK];
                    if (lastChunk) begin
                        co    <= sliceSum[CHUNK];
                        ovf   <= carryIntoMsb ^ sliceSum[CHUNK];
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= StIdle;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed self-checking bench for chunked_addsub (WIDTH=16 with CHUNK=4 and CHUNK=16).
module tb_chunked_addsub;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start16 = 1'b0;
    logic        sub = 1'b0;
    logic        ci = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        ready, done, co, ovf;
    logic [15:0] sum;
    logic        ready16, done16, co16, ovf16;
    logic [15:0] sum16;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clock(clock), .reset(reset), .start(start), .sub(sub), .ci(ci), .a(a), .b(b),
        .ready(ready), .done(done), .sum(sum), .co(co), .ovf(ovf)
    );

    chunked_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .sub(sub), .ci(ci), .a(a), .b(b),
        .ready(ready16), .done(done16), .sum(sum16), .co(co16), .ovf(ovf16)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Launch one operation and return the number of edges after acceptance until done.
    task automatic doOp(input logic [15:0] opA, input logic [15:0] opB, input logic isSub,
                        input logic cin, output int lat);
        a = opA; b = opB; sub = isSub; ci = cin; start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; sub = ~isSub; ci = ~cin;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if ({sum, co, ovf} !== 18'h0) begin failures++; $display("FAIL reset_outputs got=%h/%b/%b exp=0/0/0", sum, co, ovf); end
        checks++; if ({ready16, done16, sum16, co16, ovf16} !== {1'b1, 19'h0}) begin failures++; $display("FAIL reset_dut16 got=%b%b/%h/%b%b", ready16, done16, sum16, co16, ovf16); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add_basic();
        int lat;
        doOp(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL add_basic_latency got=%0d exp=4", lat); end
        checks++; if ({sum, co, ovf} !== {16'h5555, 1'b0, 1'b0}) begin failures++; $display("FAIL add_basic got=%h/%b/%b exp=5555/0/0", sum, co, ovf); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL add_basic_ready got=%b exp=1", ready); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_basic_pulse got=%b exp=0", done); end
        checks++; if (sum !== 16'h5555) begin failures++; $display("FAIL add_basic_hold got=%h exp=5555", sum); end
    endtask

    task automatic test_add_carry();
        int lat;
        doOp(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if ({sum, co, ovf} !== {16'h0000, 1'b1, 1'b0}) begin failures++; $display("FAIL add_ripple got=%h/%b/%b exp=0000/1/0", sum, co, ovf); end
        tick();
        doOp(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if ({sum, co, ovf} !== {16'h8000, 1'b0, 1'b1}) begin failures++; $display("FAIL add_ovf got=%h/%b/%b exp=8000/0/1", sum, co, ovf); end
        tick();
    endtask

    task automatic test_sub();
        int lat;
        doOp(16'h0005, 16'h0007, 1'b1, 1'b0, lat);
        checks++; if ({sum, co, ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin failures++; $display("FAIL sub_borrow got=%h/%b/%b exp=fffe/0/0", sum, co, ovf); end
        tick();
        doOp(16'h0010, 16'h0001, 1'b1, 1'b1, lat);
        checks++; if ({sum, co, ovf} !== {16'h000E, 1'b1, 1'b0}) begin failures++; $display("FAIL sub_borrow_in got=%h/%b/%b exp=000e/1/0", sum, co, ovf); end
        tick();
        doOp(16'h8000, 16'h0001, 1'b1, 1'b0, lat);
        checks++; if ({sum, co, ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin failures++; $display("FAIL sub_ovf got=%h/%b/%b exp=7fff/1/1", sum, co, ovf); end
        tick();
    endtask

    task automatic test_ignore_start();
        int pulses;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL busy_ready got=%b exp=0", ready); end
        tick();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ignore_done got=%b exp=1", done); end
        checks++; if (sum !== 16'h3333) begin failures++; $display("FAIL ignore_sum got=%h exp=3333", sum); end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL ignore_extra_done got=%0d exp=0", pulses); end
        checks++; if (sum !== 16'h3333) begin failures++; $display("FAIL ignore_hold got=%h exp=3333", sum); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int pulses;
        a = 16'h1234; b = 16'h4321; sub = 1'b0; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({ready, done} !== 2'b10) begin failures++; $display("FAIL abort_handshake got=%b%b exp=10", ready, done); end
        checks++; if ({sum, co, ovf} !== 18'h0) begin failures++; $display("FAIL abort_outputs got=%h/%b/%b exp=0/0/0", sum, co, ovf); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
        doOp(16'h0F0F, 16'h0101, 1'b0, 1'b1, lat);
        checks++; if (lat !== 4 || sum !== 16'h1011) begin failures++; $display("FAIL abort_restart got=%0d/%h exp=4/1011", lat, sum); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3] = '{16'h1111, 16'h0100, 16'h8000};
        logic [15:0] vb [3] = '{16'h2222, 16'h0001, 16'h8000};
        logic        vs [3] = '{1'b0, 1'b1, 1'b0};
        logic [17:0] exp [3] = '{{16'h3333, 2'b00}, {16'h00FF, 2'b10}, {16'h0000, 2'b11}};
        int lat;
        a = va[0]; b = vb[0]; sub = vs[0]; ci = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                a = va[i+1]; b = vb[i+1]; sub = vs[i+1];
            end else begin
                start = 1'b0;
            end
            lat = 0;
            while (done !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=4", i, lat); end
            checks++; if ({sum, co, ovf} !== exp[i]) begin failures++; $display("FAIL b2b_result[%0d] got=%h/%b/%b exp=%h", i, sum, co, ovf, exp[i]); end
            tick();
        end
        checks++; if ({ready, done} !== 2'b10) begin failures++; $display("FAIL b2b_idle got=%b%b exp=10", ready, done); end
    endtask

    task automatic test_chunk16();
        int lat;
        a = 16'h1234; b = 16'h4321; sub = 1'b0; ci = 1'b0; start16 = 1'b1;
        tick();
        start16 = 1'b0; a = 16'h0000; b = 16'h0000;
        lat = 0;
        while (done16 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 1) begin failures++; $display("FAIL chunk16_latency got=%0d exp=1", lat); end
        checks++; if ({sum16, co16, ovf16} !== {16'h5555, 2'b00}) begin failures++; $display("FAIL chunk16_result got=%h/%b/%b exp=5555/0/0", sum16, co16, ovf16); end
        tick();
        checks++; if ({ready16, done16} !== 2'b10) begin failures++; $display("FAIL chunk16_idle got=%b%b exp=10", ready16, done16); end
    endtask

    initial begin
        #1;
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_reset_mid_run();
        test_ignore_start();
        test_back_to_back();
        test_chunk16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
